// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional signed-overflow output is built only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_SHIFT | resolving one sum bit per edge
  // S_DONE  | result valid, done pulse; start here is accepted back-to-back
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic accept;
  logic last_bit;
  logic bit_s;
  logic bit_c;

  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST);
  assign bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign bit_c    = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs are decoded from the state flops only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    c_d    = c_q;
    sum_d  = sum_q;
    cout_d = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (accept) begin
      a_sh_d = a;
      b_sh_d = b;
      c_d    = cin;
      cnt_d  = '0;
      acc_d  = '0;
      sum_d  = '0;
      cout_d = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d  = 1'b0;
`endif
    end else if (state_q == S_SHIFT) begin
      a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
      acc_d  = {bit_s, acc_q[WIDTH-1:1]};
      c_d    = bit_c;
      cnt_d  = cnt_q + 1'b1;
      if (last_bit) begin
        sum_d  = {bit_s, acc_q[WIDTH-1:1]};
        cout_d = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
        // c_q is the carry into the MSB while the last bit is processed
        ovf_d  = c_q ^ bit_c;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, signed overflow from operand/result signs
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W:0] full;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    es = full[W-1:0];
    ec = full[W];
    eo = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
  endtask

  // One full operation from IDLE, checking every cycle up to the held result
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    logic [W-1:0] es;
    logic ec, eo;
    model(ta, tb_v, tc, es, ec, eo);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
    chk("busy_done_after_accept", {busy, done}, 2'b10);
    chk("sum_cleared_on_accept", sum, '0);
    for (int k = 2; k <= W; k++) begin
      @(negedge clk);
      chk("busy_done_in_shift", {busy, done}, 2'b10);
    end
    @(negedge clk);
    chk("busy_done_at_done", {busy, done}, 2'b01);
    chk("sum", sum, es);
    chk("cout", cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", ovf, eo);
`endif
    @(negedge clk);
    chk("done_pulse_ends", {busy, done}, 2'b00);
    chk("sum_held", {cout, sum}, {ec, es});
  endtask

  initial begin
    int dcnt;
    int first_done;
    int prev_done;
    logic [W-1:0] ra, rb;

    // Reset state
    @(negedge clk);
    chk("reset_outputs", {busy, done, cout, sum}, '0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done}, 2'b00);

    // Directed cases
    run_op(8'h3C, 8'h0F, 1'b0);
    @(negedge clk);
    chk("sum_held_idle", sum, 8'h4B);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);

    // start and a wiggled during SHIFT: no re-sample, single done
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    dcnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = (cyc <= 5);
      a = 8'hAA;
      if (done) begin
        dcnt++;
        chk("midshift_done_cycle", cyc, W + 1);
        chk("midshift_sum", sum, 8'h30);
      end
      if (cyc > W + 1) chk("midshift_no_new_op", busy, 1'b0);
    end
    chk("midshift_done_count", dcnt, 1);

    // start held high: back-to-back results every W+1 cycles
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    dcnt = 0; first_done = 0; prev_done = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      chk("b2b_busy_xor_done", busy ^ done, 1'b1);
      if (done) begin
        dcnt++;
        chk("b2b_sum", {cout, sum}, 9'h002);
        if (first_done == 0) first_done = cyc;
        else chk("b2b_interval", cyc - prev_done, W + 1);
        prev_done = cyc;
      end
    end
    chk("b2b_first_done", first_done, W + 1);
    chk("b2b_done_count", dcnt, 3);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    chk("b2b_drained", {busy, done}, 2'b00);

    // Reset mid-SHIFT aborts immediately
    @(negedge clk);
    start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {busy, done, cout, sum}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_op(8'h05, 8'h03, 1'b0);

    // Random operands
    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder, the additive counterpart to the combinational half subtractor in the combinational circuits set. It latches two operands on a start pulse and resolves the sum LSB-first, one bit per clock, using a single full-adder cell and a carry flip-flop. It then presents the parallel sum, the carry-out and a one-cycle done pulse. It is the area-minimal arithmetic unit for datapaths that can tolerate WIDTH-cycle latency.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 2–32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in, sampled with start.
- busy  output  1  high while bits are being resolved (SHIFT state).
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result a+b+cin mod 2^WIDTH; held until next accepted start.
- cout  output  1  carry out of bit WIDTH-1; held with sum.
- ovf  output  1  signed two's-complement overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- Reset (async, any state): state=IDLE; busy, done, sum, cout, ovf = 0; internal shift registers, carry FF and bit counter = 0.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge latches a, b into shift registers, cin into the carry FF, clears the counter and the sum register, and moves to SHIFT. start=0 stays in IDLE.
- SHIFT: each edge performs the following.
  - Compute s = a[0]^b[0]^c and c' = a[0]&b[0] | c&(a[0]^b[0]).
  - Shift the A and B registers right by one.
  - Shift s into the MSB of the sum register (right shift).
  - Set c <= c', counter <= counter+1.
  - On the edge processing bit WIDTH-1, move to DONE. Load sum and cout from the final values. Load ovf = carry-into-MSB ^ carry-out.
- start is ignored in SHIFT; the operands are not re-sampled and the result is unaffected.
- DONE: done=1 for exactly this cycle. The next edge goes to SHIFT if start=1 (back-to-back accept, same latch actions as in IDLE), otherwise to IDLE.
- sum, cout and ovf change only on the edge leaving SHIFT, on reset, or when a new start is accepted. On an accepted start they are cleared to 0 together with the internal sum register.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the 2^WIDTH bit. ovf uses the signed interpretation.

## Timing
- Start accepted at edge E0. SHIFT occupies edges E1..EWIDTH, with bit i resolved at edge E(i+1). done is high in the cycle after EWIDTH.
- Latency from the accepting edge to done high is WIDTH edges.
- busy is high from after E0 until after EWIDTH (WIDTH cycles). busy and done are never high together.
- Throughput with back-to-back starts is one result per WIDTH+1 cycles.
- Reset asserted mid-SHIFT aborts immediately. No done pulse is issued and outputs read 0. After rst deasserts, the first edge with start=1 is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined: the ovf port exists. It is registered and computed from the carry into bit WIDTH-1 XOR cout. It is valid and held with sum, and reset/cleared to 0 with sum.
- Undefined: there is no ovf port and no carry-into-MSB capture register. All other behaviour and timing is identical.

## Test plan
- WIDTH=8, a=0x3C, b=0x0F, cin=0, start for 1 cycle -> busy for 8 cycles; done on the 8th edge after accept; sum=0x4B, cout=0, ovf=0; outputs held afterwards.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- Change start to 1 and a to 0xAA during SHIFT of a 0x10+0x20 op -> result still 0x30. There is exactly one done, and no new op starts until IDLE/DONE.
- start held high continuously with a=0x01, b=0x01 -> done every 9 cycles, sum=0x02 each time, busy low only in the done cycles.
- Assert rst at bit 4 of a 0xF0+0x0F op -> busy, done and sum go to 0 immediately with no clock edge and no done pulse. After release, 0x05+0x03 completes with sum=0x08.
